// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM encoding and the
// packed flag vector that sits above the result word in {flags, y}.
package alu_pkg;

  localparam logic [3:0] OP_ADD       = 4'd1;
  localparam logic [3:0] OP_ADD_CARRY = 4'd2;
  localparam logic [3:0] OP_SUB       = 4'd3;
  localparam logic [3:0] OP_INC       = 4'd4;
  localparam logic [3:0] OP_DEC       = 4'd5;
  localparam logic [3:0] OP_AND       = 4'd6;
  localparam logic [3:0] OP_NOT       = 4'd7;
  localparam logic [3:0] OP_ROL       = 4'd8;
  localparam logic [3:0] OP_ROR       = 4'd9;
  localparam logic [3:0] OP_MUL       = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_BUSY = 2'd1,
    ST_DONE     = 2'd2
  } state_e;

  // Bit order matches the result vector {invalid_op, parity, zero, borrow, carry_out, y}.
  typedef struct packed {
    logic invalid_op;
    logic parity;
    logic zero;
    logic borrow;
    logic carry_out;
  } flags_t;

  localparam int FLAG_W = 5;

  function automatic logic writes_carry(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_ADD_CARRY) || (op == OP_INC);
  endfunction

endpackage

// File: rtl/alu_mul_shiftadd.sv
// Unsigned shift-add multiplier: one partial product per cycle after start,
// done_o pulses for one cycle once product_o holds the full 2*W-bit result.
module alu_mul_shiftadd #(
  parameter int W     = 8,
  parameter int CNT_W = $clog2(W + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic           done_o,
  output logic [2*W-1:0] product_o
);

  logic [2*W-1:0] mcand_q, mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic           run_q, run_d;
  logic           done_q, done_d;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    done_d   = 1'b0;
    if (start_i) begin
      mcand_d  = {{W{1'b0}}, a_i};
      mplier_d = b_i;
      acc_d    = '0;
      cnt_d    = '0;
      run_d    = 1'b1;
    end else if (run_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(W - 1)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
      done_q   <= done_d;
    end
  end

  assign done_o    = done_q;
  assign product_o = acc_q;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready in and out, an internal carry register for
// chained additions and an iterative multiply.
module alu_seq
  import alu_pkg::*;
#(
  parameter int BUS_WIDTH = 8,
  parameter int CNT_W     = $clog2(BUS_WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           opcode,
  input  logic [BUS_WIDTH-1:0] a,
  input  logic [BUS_WIDTH-1:0] b,
  input  logic                 carry_in,
  input  logic                 carry_sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] y,
  output logic                 carry_out,
  output logic                 borrow,
  output logic                 zero,
  output logic                 parity,
  output logic                 invalid_op,
  output logic                 busy
);

  state_e state_q, state_d;

  logic [BUS_WIDTH-1:0] y_q, y_d;
  flags_t               flags_q, flags_d;
  logic                 out_valid_q, out_valid_d;
  logic                 carry_q, carry_d;

  logic                   accept;
  logic                   mul_start;
  logic                   mul_done;
  logic [2*BUS_WIDTH-1:0] product;

  logic [BUS_WIDTH-1:0] alu_y;
  flags_t               alu_f;
  logic [BUS_WIDTH:0]   wide;
  logic                 cin;
  logic [BUS_WIDTH-1:0] mul_y;
  flags_t               mul_f;

  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (opcode == OP_MUL);

  alu_mul_shiftadd #(
    .W     (BUS_WIDTH),
    .CNT_W (CNT_W)
  ) u_mul (
    .clk       (clk),
    .reset     (reset),
    .start_i   (mul_start),
    .a_i       (a),
    .b_i       (b),
    .done_o    (mul_done),
    .product_o (product)
  );

  // Single-cycle result from the operands being accepted this cycle.
  always_comb begin
    alu_y = '0;
    alu_f = '0;
    wide  = '0;
    cin   = carry_sel ? carry_q : carry_in;
    case (opcode)
      OP_ADD: begin
        wide            = {1'b0, a} + {1'b0, b};
        alu_y           = wide[BUS_WIDTH-1:0];
        alu_f.carry_out = wide[BUS_WIDTH];
      end
      OP_ADD_CARRY: begin
        wide            = {1'b0, a} + {1'b0, b} + {{BUS_WIDTH{1'b0}}, cin};
        alu_y           = wide[BUS_WIDTH-1:0];
        alu_f.carry_out = wide[BUS_WIDTH];
      end
      OP_SUB: begin
        wide         = {1'b0, a} - {1'b0, b};
        alu_y        = wide[BUS_WIDTH-1:0];
        alu_f.borrow = wide[BUS_WIDTH];
      end
      OP_INC: begin
        wide            = {1'b0, a} + {{BUS_WIDTH{1'b0}}, 1'b1};
        alu_y           = wide[BUS_WIDTH-1:0];
        alu_f.carry_out = wide[BUS_WIDTH];
      end
      OP_DEC: begin
        wide         = {1'b0, a} - {{BUS_WIDTH{1'b0}}, 1'b1};
        alu_y        = wide[BUS_WIDTH-1:0];
        alu_f.borrow = wide[BUS_WIDTH];
      end
      OP_AND: alu_y = a & b;
      OP_NOT: alu_y = ~a;
      OP_ROL: alu_y = {a[BUS_WIDTH-2:0], a[BUS_WIDTH-1]};
      OP_ROR: alu_y = {a[0], a[BUS_WIDTH-1:1]};
      OP_MUL: alu_y = '0;
      default: alu_f.invalid_op = 1'b1;
    endcase
    alu_f.zero   = (alu_y == '0);
    alu_f.parity = ^alu_y;
  end

  always_comb begin
    mul_y           = product[BUS_WIDTH-1:0];
    mul_f           = '0;
    mul_f.carry_out = |product[2*BUS_WIDTH-1:BUS_WIDTH];
    mul_f.zero      = (mul_y == '0);
    mul_f.parity    = ^mul_y;
  end

  // Result registers: load on single-cycle accept or multiply completion,
  // otherwise drop out_valid once the consumer takes the result.
  always_comb begin
    y_d         = y_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q;
    carry_d     = carry_q;
    if (accept && (opcode != OP_MUL)) begin
      y_d         = alu_y;
      flags_d     = alu_f;
      out_valid_d = 1'b1;
      if (writes_carry(opcode)) begin
        carry_d = alu_f.carry_out;
      end
    end else if ((state_q == ST_MUL_BUSY) && mul_done) begin
      y_d         = mul_y;
      flags_d     = mul_f;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      y_q         <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
      carry_q     <= 1'b0;
    end else begin
      y_q         <= y_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
      carry_q     <= carry_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = (opcode == OP_MUL) ? ST_MUL_BUSY : ST_DONE;
        end
      end
      ST_MUL_BUSY: begin
        if (mul_done) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (accept) begin
          state_d = (opcode == OP_MUL) ? ST_MUL_BUSY : ST_DONE;
        end else if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The cycle the product lands is no longer counted as busy.
  always_comb begin
    in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    busy     = (state_q == ST_MUL_BUSY) && !mul_done;
  end

  assign out_valid  = out_valid_q;
  assign y          = y_q;
  assign carry_out  = flags_q.carry_out;
  assign borrow     = flags_q.borrow;
  assign zero       = flags_q.zero;
  assign parity     = flags_q.parity;
  assign invalid_op = flags_q.invalid_op;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: the driver queues hand-computed results, a
// monitor compares each result as the consumer takes it.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   opcode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         carry_in;
  logic         carry_sel;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;
  logic         carry_out;
  logic         borrow;
  logic         zero;
  logic         parity;
  logic         invalid_op;
  logic         busy;

  typedef struct {
    string                 name;
    logic [FLAG_W+W-1:0]   v;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   txn    = 0;

  always #5 clk = ~clk;

  alu_seq #(.BUS_WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .opcode     (opcode),
    .a          (a),
    .b          (b),
    .carry_in   (carry_in),
    .carry_sel  (carry_sel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .y          (y),
    .carry_out  (carry_out),
    .borrow     (borrow),
    .zero       (zero),
    .parity     (parity),
    .invalid_op (invalid_op),
    .busy       (busy)
  );

  function automatic flags_t mkf(input logic inv, par, zr, bor, car);
    flags_t f;
    f.invalid_op = inv;
    f.parity     = par;
    f.zero       = zr;
    f.borrow     = bor;
    f.carry_out  = car;
    return f;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  // Present one operation, hold it until accepted, optionally queue its result.
  task automatic issue(input string name, input logic [3:0] op, input logic [W-1:0] aa,
                       input logic [W-1:0] bb, input logic cin, input logic csel,
                       input logic [W-1:0] ey, input flags_t ef, input bit push);
    exp_t e;
    int   waited;
    opcode    = op;
    a         = aa;
    b         = bb;
    carry_in  = cin;
    carry_sel = csel;
    in_valid  = 1'b1;
    waited    = 0;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL %s accept: in_ready stayed 0 for %0d cycles, want 1", name, waited);
    end
    if (push) begin
      e.name = name;
      e.v    = {ef, ey};
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Multiply with cycle-accurate busy/in_ready/latency checks.
  task automatic mul(input string name, input logic [W-1:0] aa, input logic [W-1:0] bb,
                     input logic [W-1:0] ey, input flags_t ef);
    int cyc;
    issue(name, OP_MUL, aa, bb, 1'b0, 1'b0, ey, ef, 1'b1);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      if (cyc < 8) begin
        check({name, " busy"}, {31'd0, busy}, 32'd1);
        check({name, " in_ready"}, {31'd0, in_ready}, 32'd0);
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    check({name, " latency"}, cyc, 32'd9);
    check({name, " busy_end"}, {31'd0, busy}, 32'd0);
  endtask

  // Monitor: compare whenever a result is handed over.
  initial begin
    exp_t e;
    logic [FLAG_W+W-1:0] act;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready && !reset) begin
        act = {invalid_op, parity, zero, borrow, carry_out, y};
        checks++;
        txn++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: got 0x%0h, want no result", act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e.v) begin
            errors++;
            $display("FAIL %s: got flags/y 0x%0h, want 0x%0h", e.name, act, e.v);
          end else begin
            $display("txn %0d %s: y=%0d flags=%05b", txn, e.name, y, act[FLAG_W+W-1:W]);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    reset     = 1'b1;
    in_valid  = 1'b0;
    opcode    = 4'd0;
    a         = '0;
    b         = '0;
    carry_in  = 1'b0;
    carry_sel = 1'b0;
    out_ready = 1'b1;
    idle(2);
    check("reset in_ready", {31'd0, in_ready}, 32'd1);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset y_flags", {19'd0, invalid_op, parity, zero, borrow, carry_out, y}, 32'd0);
    reset = 1'b0;

    issue("add_200_100", OP_ADD, 8'd200, 8'd100, 1'b0, 1'b0, 8'd44, mkf(0, 1, 0, 0, 1), 1'b1);
    issue("addc_reg1", OP_ADD_CARRY, 8'd1, 8'd1, 1'b0, 1'b1, 8'd3, mkf(0, 0, 0, 0, 0), 1'b1);
    issue("addc_ext0", OP_ADD_CARRY, 8'd1, 8'd1, 1'b0, 1'b0, 8'd2, mkf(0, 1, 0, 0, 0), 1'b1);
    issue("addc_ext1", OP_ADD_CARRY, 8'd1, 8'd1, 1'b1, 1'b0, 8'd3, mkf(0, 0, 0, 0, 0), 1'b1);
    issue("add_255_1", OP_ADD, 8'd255, 8'd1, 1'b0, 1'b0, 8'd0, mkf(0, 0, 1, 0, 1), 1'b1);
    issue("addc_chain", OP_ADD_CARRY, 8'd0, 8'd0, 1'b0, 1'b1, 8'd1, mkf(0, 1, 0, 0, 0), 1'b1);
    issue("sub_5_7", OP_SUB, 8'd5, 8'd7, 1'b0, 1'b0, 8'd254, mkf(0, 1, 0, 1, 0), 1'b1);
    issue("dec_0", OP_DEC, 8'd0, 8'd0, 1'b0, 1'b0, 8'd255, mkf(0, 0, 0, 1, 0), 1'b1);
    issue("inc_255", OP_INC, 8'd255, 8'd0, 1'b0, 1'b0, 8'd0, mkf(0, 0, 1, 0, 1), 1'b1);
    issue("and", OP_AND, 8'hF0, 8'h3C, 1'b0, 1'b0, 8'h30, mkf(0, 0, 0, 0, 0), 1'b1);
    issue("rol_81", OP_ROL, 8'h81, 8'h00, 1'b0, 1'b0, 8'h03, mkf(0, 0, 0, 0, 0), 1'b1);
    issue("ror_01", OP_ROR, 8'h01, 8'h00, 1'b0, 1'b0, 8'h80, mkf(0, 1, 0, 0, 0), 1'b1);
    issue("addc_after_inc", OP_ADD_CARRY, 8'd0, 8'd0, 1'b0, 1'b1, 8'd1, mkf(0, 1, 0, 0, 0), 1'b1);

    mul("mul_15_17", 8'd15, 8'd17, 8'd255, mkf(0, 0, 0, 0, 0));
    mul("mul_16_16", 8'd16, 8'd16, 8'd0, mkf(0, 0, 1, 0, 1));
    issue("addc_after_mul", OP_ADD_CARRY, 8'd1, 8'd1, 1'b0, 1'b1, 8'd2, mkf(0, 1, 0, 0, 0), 1'b1);
    mul("mul_13_11", 8'd13, 8'd11, 8'd143, mkf(0, 1, 0, 0, 0));

    issue("op12", 4'd12, 8'h5A, 8'hA5, 1'b1, 1'b0, 8'd0, mkf(1, 0, 1, 0, 0), 1'b1);
    issue("op0", 4'd0, 8'h33, 8'h11, 1'b0, 1'b0, 8'd0, mkf(1, 0, 1, 0, 0), 1'b1);
    issue("op15", 4'd15, 8'hFF, 8'hFF, 1'b0, 1'b0, 8'd0, mkf(1, 0, 1, 0, 0), 1'b1);

    // Back-pressure: result must hold and no new op may be taken.
    idle(2);
    out_ready = 1'b0;
    issue("not_0f", OP_NOT, 8'h0F, 8'h00, 1'b0, 1'b0, 8'hF0, mkf(0, 0, 0, 0, 0), 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("hold out_valid", {31'd0, out_valid}, 32'd1);
      check("hold y_flags", {19'd0, invalid_op, parity, zero, borrow, carry_out, y}, {19'd0, 5'b00000, 8'hF0});
      check("hold in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;

    // Reset during the third multiply cycle aborts it.
    idle(2);
    issue("mul_abort", OP_MUL, 8'd7, 8'd9, 1'b0, 1'b0, 8'd0, mkf(0, 0, 0, 0, 0), 1'b0);
    idle(2);
    check("abort busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    check("abort out_valid", {31'd0, out_valid}, 32'd0);
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort in_ready", {31'd0, in_ready}, 32'd1);
    check("abort y_flags", {19'd0, invalid_op, parity, zero, borrow, carry_out, y}, 32'd0);
    idle(12);
    check("abort no_result", {31'd0, out_valid}, 32'd0);
    issue("addc_after_reset", OP_ADD_CARRY, 8'd1, 8'd1, 1'b0, 1'b1, 8'd2, mkf(0, 1, 0, 0, 0), 1'b1);

    waited = 0;
    while (exp_q.size() != 0 && waited < 50) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check("drain queue_empty", exp_q.size(), 32'd0);
    check("drain txn_count", txn, 32'd22);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Sequential, parametrised successor to the combinational 8-bit ALU.
- Accepts one operation per valid/ready handshake and returns a registered result plus flags on a second valid/ready channel.
- Adds a multi-cycle shift-add multiply (OP_MUL) and an internal carry register, so OP_ADD_CARRY can chain multi-word additions.
- Sits between a sequencer/controller and the register file in the datapath.

Parameters:
- BUS_WIDTH, 8, operand and result width (>=4).
- CNT_W, $clog2(BUS_WIDTH+1), width of the multiply iteration counter (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operation presented
- in_ready  output  1  block can accept an operation this cycle
- opcode  input  4  operation code (see package)
- a  input  BUS_WIDTH  operand A
- b  input  BUS_WIDTH  operand B
- carry_in  input  1  external carry for OP_ADD_CARRY when carry_sel=0
- carry_sel  input  1  1: OP_ADD_CARRY uses the internal carry register instead of carry_in
- out_valid  output  1  result registers hold a valid result
- out_ready  input  1  consumer accepts the result
- y  output  BUS_WIDTH  result
- carry_out  output  1  carry (add/inc) or multiply overflow
- borrow  output  1  borrow (sub/dec)
- zero  output  1  y==0
- parity  output  1  ^y
- invalid_op  output  1  opcode not in {1..10}
- busy  output  1  multiply in progress

Behaviour:
- Reset (synchronous, active-high, priority over everything):
  - Outputs: y, carry_out, borrow, zero, parity, invalid_op, out_valid and busy = 0; in_ready = 1.
  - Internal state: carry register = 0; FSM -> IDLE.
- FSM states: IDLE, MUL_BUSY, DONE.
- Accept: an operation is accepted when in_valid && in_ready. Operands and opcode are captured on that edge.
- in_ready = (state==IDLE) || (state==DONE && out_ready). Back-to-back single-cycle ops therefore sustain one operation per cycle.
- Single-cycle ops (1-9 and invalid):
  - Result is registered on the accept edge: out_valid=1 on the next cycle, latency 1.
  - FSM -> DONE.
- Op semantics (width rules):
  - ADD: {carry_out,y}=a+b
  - ADD_CARRY: {carry_out,y}=a+b+c, where c = carry_sel ? carry_reg : carry_in
  - SUB: {borrow,y}=a-b
  - INC: {carry_out,y}=a+1
  - DEC: {borrow,y}=a-1
  - AND: y=a&b
  - NOT: y=~a
  - ROL: y={a[W-2:0],a[W-1]}
  - ROR: y={a[0],a[W-1:1]}
  - Flags not listed for an op are 0.
- OP_MUL (10):
  - Accept -> MUL_BUSY, busy=1. Performs an unsigned shift-add over BUS_WIDTH iterations, one per cycle, using a 2*BUS_WIDTH accumulator.
  - After the last iteration: y = product[W-1:0], carry_out = |product[2W-1:W], borrow=0; FSM -> DONE.
  - out_valid rises exactly BUS_WIDTH+1 cycles after accept. in_ready=0 throughout MUL_BUSY.
- Invalid opcode (0, 11-15): invalid_op=1, y=0, carry_out=0, borrow=0, zero=1, parity=0. Latency 1.
- Flags: zero=(y==0) and parity=^y, computed from the result being registered, for every op including MUL.
- Carry register:
  - Updated with carry_out on completion of ADD, ADD_CARRY and INC.
  - Unchanged by all other ops, including MUL and invalid.
- DONE state:
  - All outputs hold stable while out_valid && !out_ready.
  - On out_ready: if a new op is accepted in the same cycle, it is loaded (or MUL starts); otherwise out_valid -> 0 and FSM -> IDLE.
  - Output registers keep their last value after out_valid falls.
- Reset mid-MUL: the operation is aborted, no result is produced, and the next cycle shows in_ready=1.
- in_valid while in_ready=0 is ignored; the source must hold its data until accepted.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams OP_ADD=1 … OP_ROR=9, OP_MUL=10;
  - the FSM state encoding;
  - the flag-vector bit ordering {invalid_op, parity, zero, borrow, carry_out, y}, which is shared with the bench model.
- One natural sub-module: alu_mul_shiftadd, the iterative multiplier with start/done and a registered product.

Test Plan (BUS_WIDTH=8):
- ADD a=200,b=100, out_ready=1 -> next cycle out_valid=1, y=44, carry_out=1, zero=0, parity=1; the carry register is then 1.
- Immediately follow with ADD_CARRY a=1,b=1,carry_in=0,carry_sel=1 -> y=3, carry_out=0; repeat with carry_sel=0 -> y=2.
- SUB a=5,b=7 -> y=254, borrow=1, parity=1. DEC a=0 -> y=255, borrow=1.
- MUL a=15,b=17 -> busy=1 and in_ready=0 for 8 cycles; out_valid exactly 9 cycles after accept; y=255, carry_out=0. MUL a=16,b=16 -> y=0, zero=1, carry_out=1.
- out_ready=0 for 5 cycles after NOT a=0x0F -> y=0xF0 held stable, in_ready=0. Opcode 12 -> invalid_op=1, y=0, zero=1, parity=0.
- Assert reset on the 3rd cycle of MUL -> next cycle: out_valid=0, busy=0, in_ready=1, all flags 0. A following ADD_CARRY with carry_sel=1, a=1,b=1 -> y=2.
